// File: rtl/action_selector.sv
// action_selector
//   Epsilon-greedy action chooser for a 4-action Q-learning agent.
//   A request in IDLE latches the state and epsilon. A free-running
//   16-bit Galois LFSR decides between exploring (a random action taken
//   straight from the LFSR) and exploiting (a read of the four Q-values
//   for the state, keeping the signed maximum; ties keep the lowest index).
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   en             request, only sampled in IDLE
//   epsilon[7:0]   explore threshold, probability epsilon/256
//   current_state  state whose action is chosen
//   q_rd           Q-table read strobe (READ only)
//   q_addr         {state, action index} read address, zero outside READ
//   q_data         signed Q-value, valid the cycle after q_rd
//   next_action    one-hot chosen action, held between decisions
//   action_valid   one-cycle pulse when next_action has just been updated
//   busy           high in every state except IDLE
module action_selector #(
  parameter int          Q_W       = 16,
  parameter int          S_W       = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [7:0]            epsilon,
  input  logic [S_W-1:0]        current_state,
  output logic                  q_rd,
  output logic [S_W+1:0]        q_addr,
  input  logic signed [Q_W-1:0] q_data,
  output logic [3:0]            next_action,
  output logic                  action_valid,
  output logic                  busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DRAW = 3'd1;
  localparam logic [2:0] READ = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  logic [2:0]            state;
  logic [15:0]           lfsr;
  logic [S_W-1:0]        st_lat;
  logic [7:0]            eps_lat;
  logic [1:0]            k;
  logic                  rd_p1;
  logic [1:0]            idx_p1;
  logic [1:0]            best_idx;
  logic signed [Q_W-1:0] best_val;

  logic                  explore;
  logic                  take;
  logic [1:0]            upd_idx;

  assign explore = (lfsr[7:0] < eps_lat);

  // Index 0 always seeds the running best; later candidates must be
  // strictly greater, so equal values keep the earlier (lower) index.
  assign take    = rd_p1 && ((idx_p1 == 2'd0) || (q_data > best_val));
  assign upd_idx = take ? idx_p1 : best_idx;

  assign q_rd         = (state == READ);
  assign q_addr       = q_rd ? {st_lat, k} : '0;
  assign action_valid = (state == DONE);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      st_lat      <= '0;
      eps_lat     <= '0;
      k           <= '0;
      rd_p1       <= 1'b0;
      idx_p1      <= '0;
      best_idx    <= '0;
      best_val    <= '0;
      next_action <= 4'b0000;
    end else begin
      lfsr <= lfsr_step(lfsr);

      // p1: read strobe/index delayed to line up with returning q_data
      rd_p1  <= (state == READ);
      idx_p1 <= k;

      if (take) begin
        best_idx <= idx_p1;
        best_val <= q_data;
      end

      unique case (state)
        IDLE: begin
          if (en) begin
            st_lat  <= current_state;
            eps_lat <= epsilon;
            state   <= DRAW;
          end
        end
        DRAW: begin
          k <= 2'd0;
          if (explore) begin
            next_action <= one_hot(lfsr[9:8]);
            state       <= DONE;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          k <= k + 2'd1;
          if (k == 2'd3) state <= WAIT;
        end
        WAIT: begin
          // index 3 arrives this cycle, so fold it in combinationally
          next_action <= one_hot(upd_idx);
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/action_selector.md
ACTION_SELECTOR -- requirements
Module: action_selector

Interface
- REQ-001: Parameter Q_W, default 16, signed Q-value width.
- REQ-002: Parameter S_W, default 6, state index width.
- REQ-003: Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst  input  1  asynchronous, active-high reset.
- REQ-006: en  input  1  request; sampled only in IDLE.
- REQ-007: epsilon  input  8  exploration threshold; explore probability = epsilon/256.
- REQ-008: current_state  input  S_W  state whose action is chosen.
- REQ-009: q_rd  output  1  Q-table read strobe.
- REQ-010: q_addr  output  S_W+2  read address {state, action index}.
- REQ-011: q_data  input  Q_W  signed Q-value, valid exactly one cycle after q_rd.
- REQ-012: next_action  output  4  one-hot chosen action, feeds the state-transition stage.
- REQ-013: action_valid  output  1  one-cycle pulse; next_action is new.
- REQ-014: busy  output  1  high in every state except IDLE.

Function
- REQ-015: FSM states IDLE, DRAW, READ, WAIT, DONE; registered state.
- REQ-016: IDLE: en=1 at a clock edge latches current_state and epsilon, goes to DRAW; en=0 stays in IDLE.
- REQ-017: en is ignored whenever busy=1; no request queuing.
- REQ-018: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advances every cycle in all states, never zero.
- REQ-019: DRAW (one cycle): if lfsr[7:0] < latched epsilon (unsigned), explore: action index = lfsr[9:8], go to DONE; else go to READ.
- REQ-020: READ lasts exactly 4 cycles: q_rd=1, q_addr={latched state, k}, k=0,1,2,3 in order.
- REQ-021: q_data for index k sampled in the cycle after its read; WAIT (one cycle) captures index 3, then DONE.
- REQ-022: Greedy compare is signed; a candidate replaces best only if strictly greater; ties keep the lowest index; index 0 initialises best.
- REQ-023: DONE (one cycle): action_valid=1, next_action=one-hot(best index); go to IDLE.
- REQ-024: Latency from the en-sampling edge: explore, action_valid in 2nd cycle after; exploit, in 7th cycle after.
- REQ-025: next_action holds its value between DONE pulses.
- REQ-026: epsilon=0 never explores; epsilon=255 explores unless lfsr[7:0]=255.
- REQ-027: q_rd=0 and q_addr=0 outside READ.

Reset
- REQ-028: On rst=1, immediately and regardless of clk: state=IDLE, q_rd=0, q_addr=0, action_valid=0, busy=0, next_action=4'b0000, LFSR=LFSR_SEED, best index/value cleared.
- REQ-029: rst asserted mid-operation aborts the decision; no action_valid pulse for it after release.
- REQ-030: First en after rst release is accepted normally.

Verification
- REQ-031: epsilon=0, state=5, Q[5]={-5,100,100,3}: q_addr 20,21,22,23 on cycles 2-5, then next_action=4'b0010, action_valid in cycle 7.
- REQ-032: epsilon=0, Q={-300,-2,-7,-2}: next_action=4'b0010; check signed compare and tie rule.
- REQ-033: epsilon=255, run 64 requests against a bit-accurate LFSR model: each explore has q_rd never high, action_valid 2 cycles after en, next_action=one-hot(lfsr[9:8]).
- REQ-034: en held high continuously for 20 cycles, epsilon=0: exactly 2 action_valid pulses (cycles 7 and 15); busy never drops mid-decision.
- REQ-035: rst pulsed during READ cycle 3: q_rd drops the same cycle, no action_valid follows, next_action=4'b0000; next request completes normally.
- REQ-036: Randomised epsilon and Q contents vs. reference model: next_action, latency and q_addr sequence match on every request.
